// File: rtl/sha256_pkg.sv
// Shared constants, types and helper functions for the SHA-256 PCPI coprocessor.
// Holds the round constant table, the initial hash value and the FSM state encoding.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] FUNCT3_SHA     = 3'b000;

    localparam logic [6:0] SHA_INIT = 7'h00;
    localparam logic [6:0] SHA_LDW  = 7'h01;
    localparam logic [6:0] SHA_RUN  = 7'h02;
    localparam logic [6:0] SHA_RDH  = 7'h03;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StFinal,
        StDone
    } state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/pcpi_sha256_core_if.sv
// picorv32 PCPI bundle; the CPU side is the master, the coprocessor the slave.
interface pcpi_sha256_core_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid,
        output pcpi_insn,
        output pcpi_rs1,
        output pcpi_rs2,
        input  pcpi_wr,
        input  pcpi_rd,
        input  pcpi_wait,
        input  pcpi_ready
    );

    modport slave (
        input  pcpi_valid,
        input  pcpi_insn,
        input  pcpi_rs1,
        input  pcpi_rs2,
        output pcpi_wr,
        output pcpi_rd,
        output pcpi_wait,
        output pcpi_ready
    );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: maps working variables a..h to their next values.
// Also hosts the message schedule sigma functions used by the expander in the top.
module sha256_round
    import sha256_pkg::*;
(
    input  word_t vars_i [8],
    input  word_t kt_i,
    input  word_t wt_i,
    input  word_t sched_m2_i,
    input  word_t sched_m15_i,
    output word_t vars_o [8],
    output word_t sig1_m2_o,
    output word_t sig0_m15_o
);

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = vars_i[7] + big_sigma1(vars_i[4]) + ch(vars_i[4], vars_i[5], vars_i[6])
             + kt_i + wt_i;
        t2 = big_sigma0(vars_i[0]) + maj(vars_i[0], vars_i[1], vars_i[2]);
        vars_o[0] = t1 + t2;
        vars_o[1] = vars_i[0];
        vars_o[2] = vars_i[1];
        vars_o[3] = vars_i[2];
        vars_o[4] = vars_i[3] + t1;
        vars_o[5] = vars_i[4];
        vars_o[6] = vars_i[5];
        vars_o[7] = vars_i[6];
    end

    assign sig1_m2_o  = small_sigma1(sched_m2_i);
    assign sig0_m15_o = small_sigma0(sched_m15_i);

endmodule

// File: rtl/pcpi_sha256_core.sv
// SHA-256 compression coprocessor on the picorv32 PCPI port: holds H0..H7 and a
// 16-word rolling message window, and runs one 64-round compression per SHA_RUN.
module pcpi_sha256_core
    import sha256_pkg::*;
#(
    parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
    parameter logic [2:0] FUNCT3 = FUNCT3_SHA
) (
    input logic               clk,
    input logic               resetn,
    pcpi_sha256_core_if.slave pcpi
);

    state_e     state_q, state_d;
    logic [5:0] t_q, t_d;
    word_t      h_q [8];
    word_t      h_d [8];
    word_t      w_q [16];
    word_t      w_d [16];
    word_t      v_q [8];
    word_t      v_d [8];
    logic       wait_q, wait_d;
    logic       ready_q, ready_d;
    logic       wr_q, wr_d;
    word_t      rd_q, rd_d;

    // Decode
    logic [6:0] funct7;
    logic       insn_hit;
    logic       accept;

    assign funct7   = pcpi.pcpi_insn[31:25];
    assign insn_hit = pcpi.pcpi_valid && (pcpi.pcpi_insn[6:0] == OPCODE) &&
                      (pcpi.pcpi_insn[14:12] == FUNCT3) && (funct7[6:2] == 5'd0);
    assign accept   = insn_hit && (state_q == StIdle);

    logic unused_bits;
    assign unused_bits = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7], pcpi.pcpi_rs2[31:4]};

    // Message schedule expander over the 16-word circular window
    logic [3:0] t_lo, idx_m2, idx_m7, idx_m15;
    word_t      wt, sig1_m2, sig0_m15, kt;

    assign t_lo    = t_q[3:0];
    assign idx_m2  = t_lo - 4'd2;
    assign idx_m7  = t_lo - 4'd7;
    assign idx_m15 = t_lo - 4'd15;
    assign kt      = K[t_q];

    always_comb begin
        if (t_q < 6'd16) begin
            wt = w_q[t_lo];
        end else begin
            wt = sig1_m2 + w_q[idx_m7] + sig0_m15 + w_q[t_lo];
        end
    end

    // Round 0 runs in LOAD straight from H, which saves a cycle on every RUN.
    word_t round_in  [8];
    word_t round_out [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            round_in[i] = (state_q == StLoad) ? h_q[i] : v_q[i];
        end
    end

    sha256_round u_round (
        .vars_i      (round_in),
        .kt_i        (kt),
        .wt_i        (wt),
        .sched_m2_i  (w_q[idx_m2]),
        .sched_m15_i (w_q[idx_m15]),
        .vars_o      (round_out),
        .sig1_m2_o   (sig1_m2),
        .sig0_m15_o  (sig0_m15)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        h_d     = h_q;
        w_d     = w_q;
        v_d     = v_q;
        rd_d    = rd_q;
        wr_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StDone;
                    case (funct7)
                        SHA_INIT: begin
                            h_d = IV;
                            for (int i = 0; i < 16; i++) w_d[i] = '0;
                        end
                        SHA_LDW:  w_d[pcpi.pcpi_rs2[3:0]] = pcpi.pcpi_rs1;
                        SHA_RDH: begin
                            rd_d = h_q[pcpi.pcpi_rs1[2:0]];
                            wr_d = 1'b1;
                        end
                        SHA_RUN: begin
                            t_d     = '0;
                            state_d = StLoad;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StLoad, StRound: begin
                v_d = round_out;
                if (t_q >= 6'd16) w_d[t_lo] = wt;
                t_d     = t_q + 6'd1;
                state_d = (t_q == 6'd63) ? StFinal : StRound;
            end
            StFinal: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StDone);
        wait_d  = (state_d == StLoad) || (state_d == StRound) || (state_d == StFinal);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            t_q     <= '0;
            h_q     <= IV;
            w_q     <= '{default: '0};
            v_q     <= '{default: '0};
            wait_q  <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            h_q     <= h_d;
            w_q     <= w_d;
            v_q     <= v_d;
            wait_q  <= wait_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign pcpi.pcpi_wait  = wait_q;
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = wr_q;
    assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_sha256_core.sv
// Directed and randomized bench for pcpi_sha256_core against a plain SHA-256 model.
module tb_pcpi_sha256_core;

    localparam logic [6:0] OPC  = 7'b0001011;
    localparam logic [2:0] F3   = 3'b000;
    localparam logic [6:0] FINIT = 7'h00;
    localparam logic [6:0] FLDW  = 7'h01;
    localparam logic [6:0] FRUN  = 7'h02;
    localparam logic [6:0] FRDH  = 7'h03;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IVT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic clk;
    logic resetn;
    int   n_pass;
    int   n_total;

    logic [31:0] m_h [8];
    logic [31:0] m_w [16];
    logic [31:0] blk [16];

    pcpi_sha256_core_if bus ();

    pcpi_sha256_core dut (
        .clk    (clk),
        .resetn (resetn),
        .pcpi   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    // Reference: textbook FIPS 180-4 compression with a full 64-entry schedule.
    task automatic model_run();
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m_w[i];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = m_h[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) m_h[i] = m_h[i] + v[i];
        for (int j = 0; j < 16; j++) m_w[j] = w[48 + j];
    endtask

    // Valid stays up through the ready cycle and the edge after it.
    task automatic issue(input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int exp_lat, input string tag, output logic [31:0] rd);
        int   lat;
        int   waits;
        logic got, both, wr_seen, extra;
        lat = -1; waits = 0; got = 0; both = 0; wr_seen = 0; extra = 0; rd = '0;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(f7, F3, OPC);
        bus.pcpi_rs1   = rs1;
        bus.pcpi_rs2   = rs2;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (bus.pcpi_wait) waits++;
            if (bus.pcpi_wait && bus.pcpi_ready) both = 1'b1;
            if (bus.pcpi_ready) begin
                got = 1'b1; lat = c; rd = bus.pcpi_rd; wr_seen = bus.pcpi_wr;
            end
        end
        @(negedge clk);
        if (bus.pcpi_ready) extra = 1'b1;
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        if (bus.pcpi_ready) extra = 1'b1;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_wait_cycles"}, waits, exp_lat - 1);
        check({tag, "_wr"}, {31'd0, wr_seen}, {31'd0, f7 == FRDH});
        check({tag, "_wait_with_ready"}, {31'd0, both}, 32'd0);
        check({tag, "_extra_ready"}, {31'd0, extra}, 32'd0);
    endtask

    task automatic issue_bad(input logic [31:0] insn, input string tag);
        int n_w, n_r, n_wr;
        n_w = 0; n_r = 0; n_wr = 0;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = $urandom();
        bus.pcpi_rs2   = $urandom();
        repeat (20) begin
            @(negedge clk);
            if (bus.pcpi_wait) n_w++;
            if (bus.pcpi_ready) n_r++;
            if (bus.pcpi_wr) n_wr++;
        end
        bus.pcpi_valid = 1'b0;
        check({tag, "_wait"}, n_w, 0);
        check({tag, "_ready"}, n_r, 0);
        check({tag, "_wr"}, n_wr, 0);
    endtask

    task automatic do_init();
        logic [31:0] rd;
        issue(FINIT, $urandom(), $urandom(), 1, "init", rd);
        for (int i = 0; i < 8; i++) m_h[i] = IVT[i];
        for (int i = 0; i < 16; i++) m_w[i] = '0;
    endtask

    task automatic load_block(input logic reverse);
        logic [31:0] rd, r;
        logic [3:0]  idx;
        for (int i = 0; i < 16; i++) begin
            idx = reverse ? 4'(15 - i) : 4'(i);
            r   = $urandom();
            issue(FLDW, blk[idx], {r[31:4], idx}, 1, "ldw", rd);
            m_w[idx] = blk[idx];
        end
    endtask

    task automatic do_run(input string tag);
        logic [31:0] rd;
        issue(FRUN, $urandom(), $urandom(), 66, tag, rd);
        model_run();
    endtask

    task automatic rdh(input logic [2:0] idx, input string tag, output logic [31:0] rd);
        logic [31:0] r;
        r = $urandom();
        issue(FRDH, {r[31:3], idx}, $urandom(), 1, tag, rd);
    endtask

    task automatic check_digest(input string tag);
        logic [31:0] rd;
        for (int i = 0; i < 8; i++) begin
            rdh(3'(i), tag, rd);
            check($sformatf("%s_H%0d", tag, i), rd, m_h[i]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        n_pass = 0;
        n_total = 0;
        resetn = 1'b0;
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;
        repeat (3) @(negedge clk);
        check("reset_wait", {31'd0, bus.pcpi_wait}, 32'd0);
        check("reset_ready", {31'd0, bus.pcpi_ready}, 32'd0);
        check("reset_wr", {31'd0, bus.pcpi_wr}, 32'd0);
        check("reset_rd", bus.pcpi_rd, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) m_h[i] = IVT[i];
        for (int i = 0; i < 16; i++) m_w[i] = '0;

        // INIT then read back the IV
        do_init();
        for (int i = 0; i < 8; i++) begin
            rdh(3'(i), "rdh_iv", rd);
            check($sformatf("iv_H%0d", i), rd, IVT[i]);
        end

        // "abc"
        do_init();
        blk = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        load_block(1'b0);
        do_run("run_abc");
        rdh(3'd0, "rdh_abc0", rd);
        check("abc_H0", rd, 32'hba7816bf);
        rdh(3'd7, "rdh_abc7", rd);
        check("abc_H7", rd, 32'hf20015ad);
        check_digest("abc");

        // Two-block message
        do_init();
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 0};
        load_block(1'b0);
        do_run("run_2blk_a");
        blk = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
        load_block(1'b1);
        do_run("run_2blk_b");
        rdh(3'd0, "rdh_2blk0", rd);
        check("twoblk_H0", rd, 32'h248d6a61);
        rdh(3'd7, "rdh_2blk7", rd);
        check("twoblk_H7", rd, 32'h19db06c1);

        // Random chained blocks
        for (int k = 0; k < 3; k++) begin
            if (k == 0) do_init();
            for (int i = 0; i < 16; i++) blk[i] = $urandom();
            load_block(k[0]);
            do_run("run_rand");
            check_digest($sformatf("rand%0d", k));
        end

        // Reset in the middle of round t=30
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        load_block(1'b0);
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(FRUN, F3, OPC);
        repeat (31) @(negedge clk);
        check("midrun_wait_before", {31'd0, bus.pcpi_wait}, 32'd1);
        resetn = 1'b0;
        bus.pcpi_valid = 1'b0;
        #1;
        check("midrun_wait", {31'd0, bus.pcpi_wait}, 32'd0);
        check("midrun_ready", {31'd0, bus.pcpi_ready}, 32'd0);
        check("midrun_wr", {31'd0, bus.pcpi_wr}, 32'd0);
        check("midrun_rd", bus.pcpi_rd, 32'd0);
        for (int i = 0; i < 8; i++) m_h[i] = IVT[i];
        for (int i = 0; i < 16; i++) m_w[i] = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rdh(3'd0, "rdh_after_reset", rd);
        check("after_reset_H0", rd, 32'h6a09e667);
        do_run("run_after_reset");
        check_digest("after_reset");

        // Instructions that must not be claimed
        issue_bad(mk_insn(7'h05, F3, OPC), "bad_funct7");
        issue_bad(mk_insn(FRDH, 3'b001, OPC), "bad_funct3");
        issue_bad(mk_insn(FINIT, F3, 7'b0101011), "bad_opcode");
        rdh(3'd2, "rdh_after_bad", rd);
        check("after_bad_H2", rd, m_h[2]);

        // Back-to-back short ops
        for (int i = 0; i < 4; i++) begin
            blk[0] = $urandom();
            issue(FLDW, blk[0], 32'(i), 1, "b2b_ldw", rd);
            rdh(3'(i + 4), "b2b_rdh", rd);
            check($sformatf("b2b_H%0d", i + 4), rd, m_h[i + 4]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
